// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared constants and types for the MEM->WB pipeline register of the
//   128-bit vector datapath.
//
//   DATA_W   : width of memory read data and ALU result. Vectors use
//              big-endian numbering [0:DATA_W-1], so bit 0 is the MSB.
//   BYTEEN_W : one write-enable bit per byte lane (DATA_W/8). Bit 0 is the
//              most significant byte lane.
//   RADDR_W  : register-file destination address width (32 entries).
//
//   mem_wb_t bundles every field that crosses the MEM/WB boundary. It gives
//   the top level one named view of the stage inputs.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned BYTEEN_W = DATA_W / 8;
    localparam int unsigned RADDR_W  = 5;

    // Field order follows the positional port order of pipe_3.
    typedef struct packed {
        logic [0:DATA_W-1]   dataOut;     // memory read data
        logic [0:BYTEEN_W-1] wbyteen;     // register-file byte-lane write mask
        logic                regwren;     // register-file write enable
        logic [RADDR_W-1:0]  rwraddrd;    // destination register
        logic                reginmuxop;  // 1 = take dataOut, 0 = take aluOut
        logic [0:DATA_W-1]   aluOut;      // ALU result
    } mem_wb_t;

endpackage : pipe_pkg

// File: rtl/pipe_dff.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipe_dff
//   W-bit register with synchronous, active-high reset to zero.
//   Capture is unconditional: no enable. Any X on d is stored as-is.
//   Bit i of d always lands in bit i of q.
//
//   Ports
//     clk    in   1   rising-edge clock
//     reset  in   1   synchronous active-high reset, clears q to 0
//     d      in   W   next value
//     q      out  W   registered value (driven directly by the flop)
// ---------------------------------------------------------------------------
module pipe_dff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:W-1] d,
    output logic [0:W-1] q
);

    logic [0:W-1] q_d;
    logic [0:W-1] q_q;

    // The next state is the input itself. This stage is pure storage.
    always_comb begin
        q_d = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : pipe_dff

// File: rtl/pipe_3.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipe_3
//   MEM -> WB pipeline register of the 128-bit vector datapath.
//   Every rising clk edge captures the memory read data, the ALU result and
//   the write-back control. The write-back stage sees them one cycle later.
//   There is no stall, no flush and no logic on the data path.
//
//   A synchronous active-high reset clears every output at the edge where it
//   is sampled. Inputs are ignored at that edge. All outputs come directly
//   from flops, so no input reaches an output combinationally.
//
//   Ports (in positional order)
//     dataOut_in      in   128  memory read data (bit 0 = MSB)
//     dataOut_out     out  128  registered dataOut_in
//     wbyteen_in      in   16   byte-lane write mask (bit 0 = MS lane)
//     wbyteen_out     out  16   registered wbyteen_in
//     regwren_in      in   1    register-file write enable
//     regwren_out     out  1    registered regwren_in
//     rwraddrd_in     in   5    destination register address
//     rwraddrd_out    out  5    registered rwraddrd_in
//     reginmuxop_in   in   1    WB mux select (1 = memory, 0 = ALU)
//     reginmuxop_out  out  1    registered reginmuxop_in
//     aluOut_in       in   128  ALU result
//     aluOut_out      out  128  registered aluOut_in
//     clk             in   1    rising-edge clock
//     reset           in   1    synchronous active-high reset
// ---------------------------------------------------------------------------
module pipe_3
    import pipe_pkg::*;
(
    input  logic [0:127] dataOut_in,
    output logic [0:127] dataOut_out,
    input  logic [0:15]  wbyteen_in,
    output logic [0:15]  wbyteen_out,
    input  logic         regwren_in,
    output logic         regwren_out,
    input  logic [4:0]   rwraddrd_in,
    output logic [4:0]   rwraddrd_out,
    input  logic         reginmuxop_in,
    output logic         reginmuxop_out,
    input  logic [0:127] aluOut_in,
    output logic [0:127] aluOut_out,
    input  logic         clk,
    input  logic         reset
);

    mem_wb_t stage_d;

    logic [0:DATA_W-1]   dataOut_q;
    logic [0:BYTEEN_W-1] wbyteen_q;
    logic                regwren_q;
    logic [RADDR_W-1:0]  rwraddrd_q;
    logic                reginmuxop_q;
    logic [0:DATA_W-1]   aluOut_q;

    // Gather the MEM-stage signals into one bundle. Plain copies only,
    // with no gating or sanitising.
    always_comb begin
        stage_d            = '0;
        stage_d.dataOut    = dataOut_in;
        stage_d.wbyteen    = wbyteen_in;
        stage_d.regwren    = regwren_in;
        stage_d.rwraddrd   = rwraddrd_in;
        stage_d.reginmuxop = reginmuxop_in;
        stage_d.aluOut     = aluOut_in;
    end

    // One register per field. Each resets to zero independently.
    pipe_dff #(.W(DATA_W)) u_dataout_reg (
        .clk   (clk),
        .reset (reset),
        .d     (stage_d.dataOut),
        .q     (dataOut_q)
    );

    pipe_dff #(.W(BYTEEN_W)) u_wbyteen_reg (
        .clk   (clk),
        .reset (reset),
        .d     (stage_d.wbyteen),
        .q     (wbyteen_q)
    );

    pipe_dff #(.W(1)) u_regwren_reg (
        .clk   (clk),
        .reset (reset),
        .d     (stage_d.regwren),
        .q     (regwren_q)
    );

    pipe_dff #(.W(RADDR_W)) u_rwraddrd_reg (
        .clk   (clk),
        .reset (reset),
        .d     (stage_d.rwraddrd),
        .q     (rwraddrd_q)
    );

    pipe_dff #(.W(1)) u_reginmuxop_reg (
        .clk   (clk),
        .reset (reset),
        .d     (stage_d.reginmuxop),
        .q     (reginmuxop_q)
    );

    pipe_dff #(.W(DATA_W)) u_aluout_reg (
        .clk   (clk),
        .reset (reset),
        .d     (stage_d.aluOut),
        .q     (aluOut_q)
    );

    assign dataOut_out    = dataOut_q;
    assign wbyteen_out    = wbyteen_q;
    assign regwren_out    = regwren_q;
    assign rwraddrd_out   = rwraddrd_q;
    assign reginmuxop_out = reginmuxop_q;
    assign aluOut_out     = aluOut_q;

endmodule : pipe_3

// File: tb/tb_pipe_3.sv
`timescale 1ns/1ps
// Directed bench for the MEM->WB pipeline register.
// The clock has a 10 ns period with rising edges at 10, 20, 30 ns and so on.
// Outputs are sampled 1 ns after a rising edge, or mid-cycle where the
// check is about what happens between edges.
module tb_pipe_3;

    logic [0:127] dataOut_in,  dataOut_out;
    logic [0:15]  wbyteen_in,  wbyteen_out;
    logic         regwren_in,  regwren_out;
    logic [4:0]   rwraddrd_in, rwraddrd_out;
    logic         reginmuxop_in, reginmuxop_out;
    logic [0:127] aluOut_in,   aluOut_out;
    logic         clk;
    logic         reset;

    int tests_run;
    int tests_failed;

    pipe_3 dut (
        .dataOut_in     (dataOut_in),
        .dataOut_out    (dataOut_out),
        .wbyteen_in     (wbyteen_in),
        .wbyteen_out    (wbyteen_out),
        .regwren_in     (regwren_in),
        .regwren_out    (regwren_out),
        .rwraddrd_in    (rwraddrd_in),
        .rwraddrd_out   (rwraddrd_out),
        .reginmuxop_in  (reginmuxop_in),
        .reginmuxop_out (reginmuxop_out),
        .aluOut_in      (aluOut_in),
        .aluOut_out     (aluOut_out),
        .clk            (clk),
        .reset          (reset)
    );

    // The clock starts high, falls at 5 ns and rises at 10, 20, 30 ns and so on.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [0:127] e_data, input logic [0:15] e_wbe,
                           input logic e_wren, input logic [4:0] e_addr,
                           input logic e_mux, input logic [0:127] e_alu);
        chk({tag, ".dataOut"},    dataOut_out,    e_data);
        chk({tag, ".wbyteen"},    wbyteen_out,    e_wbe);
        chk({tag, ".regwren"},    regwren_out,    e_wren);
        chk({tag, ".rwraddrd"},   rwraddrd_out,   e_addr);
        chk({tag, ".reginmuxop"}, reginmuxop_out, e_mux);
        chk({tag, ".aluOut"},     aluOut_out,     e_alu);
    endtask

    task automatic drive(input logic [0:127] d, input logic [0:15] w, input logic we,
                         input logic [4:0] a, input logic m, input logic [0:127] alu);
        dataOut_in    = d;
        wbyteen_in    = w;
        regwren_in    = we;
        rwraddrd_in   = a;
        reginmuxop_in = m;
        aluOut_in     = alu;
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [0:127] F_TOP = {4'hF, 124'h0};
    localparam logic [0:127] ONES  = {128{1'b1}};
    localparam logic [0:127] PAT_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [0:127] PAT_B = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    localparam logic [0:127] PAT_C = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    localparam logic [0:127] PAT_D = 128'h8000_0000_0000_0000_0000_0000_0000_0007;

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset is held across the 10 and 20 ns edges. Inputs are all ones
        // during reset and must be ignored.
        reset = 1'b1;
        drive(ONES, 16'hFFFF, 1'b1, 5'b11111, 1'b1, ONES);
        edge_then_settle();                               // 11 ns
        chk_all("reset_10", '0, 16'h0000, 1'b0, 5'b00000, 1'b0, '0);
        edge_then_settle();                               // 21 ns
        chk_all("reset_20", '0, 16'h0000, 1'b0, 5'b00000, 1'b0, '0);

        // Capture: drive at 25 ns. Outputs must be unchanged until the 30 ns edge.
        #4;                                               // 25 ns
        reset = 1'b0;
        drive(F_TOP, 16'hF000, 1'b1, 5'b10000, 1'b1, F_TOP);
        #1;                                               // 26 ns
        chk_all("pre_edge", '0, 16'h0000, 1'b0, 5'b00000, 1'b0, '0);
        edge_then_settle();                               // 31 ns
        chk_all("capture", F_TOP, 16'hF000, 1'b1, 5'b10000, 1'b1, F_TOP);

        // Back-to-back: a new value every cycle, each seen exactly one edge later.
        drive(PAT_A, 16'h00FF, 1'b0, 5'd1, 1'b0, 128'd1);
        edge_then_settle();                               // 41 ns
        chk_all("b2b_1", PAT_A, 16'h00FF, 1'b0, 5'd1, 1'b0, 128'd1);
        drive(PAT_B, 16'h0F0F, 1'b1, 5'd2, 1'b1, 128'd2);
        edge_then_settle();                               // 51 ns
        chk_all("b2b_2", PAT_B, 16'h0F0F, 1'b1, 5'd2, 1'b1, 128'd2);
        drive(PAT_C, 16'hA5A5, 1'b0, 5'd3, 1'b0, 128'd3);
        edge_then_settle();                               // 61 ns
        chk_all("b2b_3", PAT_C, 16'hA5A5, 1'b0, 5'd3, 1'b0, 128'd3);

        // Mid-stream reset: a one-edge pulse clears everything. The following
        // edge captures whatever is currently on the inputs.
        reset = 1'b1;
        drive(PAT_D, 16'h8001, 1'b1, 5'd17, 1'b1, PAT_A);
        edge_then_settle();                               // 71 ns
        chk_all("mid_reset", '0, 16'h0000, 1'b0, 5'b00000, 1'b0, '0);
        reset = 1'b0;
        edge_then_settle();                               // 81 ns
        chk_all("post_reset", PAT_D, 16'h8001, 1'b1, 5'd17, 1'b1, PAT_A);

        // A reset pulse between edges must have no effect.
        drive(PAT_B, 16'h1234, 1'b0, 5'd9, 1'b0, PAT_C);
        #2 reset = 1'b1;                                  // 83 ns
        #2 reset = 1'b0;                                  // 85 ns
        #1;                                               // 86 ns
        chk_all("sync_hold", PAT_D, 16'h8001, 1'b1, 5'd17, 1'b1, PAT_A);
        edge_then_settle();                               // 91 ns
        chk_all("sync_next", PAT_B, 16'h1234, 1'b0, 5'd9, 1'b0, PAT_C);

        // Bit order: a value of 1 sets the highest-numbered bit of the
        // big-endian vectors.
        drive(128'h1, 16'h0001, 1'b0, 5'b00001, 1'b0, '0);
        edge_then_settle();                               // 101 ns
        chk_all("bitord", 128'h1, 16'h0001, 1'b0, 5'b00001, 1'b0, '0);
        chk("bitord.data127", dataOut_out[127], 1'b1);
        chk("bitord.data0",   dataOut_out[0],   1'b0);
        chk("bitord.wbe15",   wbyteen_out[15],  1'b1);
        chk("bitord.wbe0",    wbyteen_out[0],   1'b0);
        chk("bitord.addr0",   rwraddrd_out[0],  1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pipe_3
